bcd_up_counter: RTL and testbench

//  Two-digit BCD up counter, 00 -> 99, with synchronous preset load, global enable and count-tick enable.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/up_counter.sv | 30 +++
 rtl/bcd_up_counter.sv | 63 ++++++
 tb/tb_bcd_up_counter.sv | 111 +++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and increment helper
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Returns {carry, next_digit}; anything at or above 9 wraps to 0 with carry.
  function automatic logic [4:0] bcd_inc(input bcd_digit_t d);
    logic carry;
    carry = (d >= BCD_MAX);
    return {carry, carry ? BCD_MIN : bcd_digit_t'(d + 4'd1)};
  endfunction

endpackage

// File: rtl/up_counter.sv
// rtl/up_counter.sv - single BCD digit up counter with preset load
module up_counter
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       loadN,
  input  logic       ena,
  input  logic       ena_cnt,
  input  bcd_digit_t datain,
  output bcd_digit_t count,
  output logic       tc
);

  logic [4:0] inc_result;

  assign inc_result = bcd_inc(count);
  assign tc         = (count == BCD_MAX);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      count <= BCD_MIN;
    end else if (!loadN) begin
      count <= datain;
    end else if (ena && ena_cnt) begin
      count <= inc_result[3:0];
    end
  end

endmodule

// File: rtl/bcd_up_counter.sv
// rtl/bcd_up_counter.sv - two-digit BCD up counter 00..99 with wrap/saturate and overflow pulse
module bcd_up_counter
  import bcd_pkg::*;
#(
  parameter bcd_digit_t datainL = 4'h0,
  parameter bcd_digit_t datainH = 4'h0,
  parameter bit         WRAP    = 1'b1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       loadN,
  input  logic       ena,
  input  logic       ena_cnt,
  output bcd_digit_t countL,
  output bcd_digit_t countH,
  output logic       tc,
  output logic       overflow
);

  if (datainL > BCD_MAX || datainH > BCD_MAX) begin : g_bad_preset
    $error("bcd_up_counter: preset digits must be 0..9");
  end

  logic tclow;
  logic tchigh;
  logic ena_cnt_eff;

  // In saturate mode a tick at 99 is swallowed so neither digit moves.
  assign ena_cnt_eff = ena_cnt && !(tc && !WRAP);

  up_counter u_low (
    .clk     (clk),
    .resetN  (resetN),
    .loadN   (loadN),
    .ena     (ena),
    .ena_cnt (ena_cnt_eff),
    .datain  (datainL),
    .count   (countL),
    .tc      (tclow)
  );

  up_counter u_high (
    .clk     (clk),
    .resetN  (resetN),
    .loadN   (loadN),
    .ena     (ena),
    .ena_cnt (tclow && ena_cnt_eff),
    .datain  (datainH),
    .count   (countH),
    .tc      (tchigh)
  );

  assign tc = tclow && tchigh;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      overflow <= 1'b0;
    end else begin
      overflow <= loadN && ena && ena_cnt && tc && WRAP;
    end
  end

endmodule

// File: tb/tb_bcd_up_counter.sv
// tb/tb_bcd_up_counter.sv - directed self-checking bench for bcd_up_counter
module tb_bcd_up_counter;

  logic clk = 1'b0;
  logic resetN, loadN, ena, ena_cnt;

  logic [3:0] l12, h12, l98, h98, l98s, h98s, l07, h07;
  logic tc12, tc98, tc98s, tc07;
  logic ov12, ov98, ov98s, ov07;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // All instances share the stimulus; each phase checks the instance whose preset it uses.
  bcd_up_counter #(.datainL(4'd2), .datainH(4'd1), .WRAP(1'b1)) u12 (
    .clk(clk), .resetN(resetN), .loadN(loadN), .ena(ena), .ena_cnt(ena_cnt),
    .countL(l12), .countH(h12), .tc(tc12), .overflow(ov12));
  bcd_up_counter #(.datainL(4'd8), .datainH(4'd9), .WRAP(1'b1)) u98 (
    .clk(clk), .resetN(resetN), .loadN(loadN), .ena(ena), .ena_cnt(ena_cnt),
    .countL(l98), .countH(h98), .tc(tc98), .overflow(ov98));
  bcd_up_counter #(.datainL(4'd8), .datainH(4'd9), .WRAP(1'b0)) u98s (
    .clk(clk), .resetN(resetN), .loadN(loadN), .ena(ena), .ena_cnt(ena_cnt),
    .countL(l98s), .countH(h98s), .tc(tc98s), .overflow(ov98s));
  bcd_up_counter #(.datainL(4'd7), .datainH(4'd0), .WRAP(1'b1)) u07 (
    .clk(clk), .resetN(resetN), .loadN(loadN), .ena(ena), .ena_cnt(ena_cnt),
    .countL(l07), .countH(h07), .tc(tc07), .overflow(ov07));

  task automatic step(input logic rn, input logic ln, input logic en, input logic ec);
    resetN  = rn;
    loadN   = ln;
    ena     = en;
    ena_cnt = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetN = 1'b1; loadN = 1'b1; ena = 1'b0; ena_cnt = 1'b0;
    #2;

    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("reset_count", {8'h0, h12, l12}, 16'h0000);
    check("reset_tc", {15'h0, tc12}, 16'h0);
    check("reset_ov", {15'h0, ov12}, 16'h0);
    check("reset_other", {h98, l98, h07, l07}, 16'h0000);

    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("load_12", {8'h0, h12, l12}, 16'h0012);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    check("count_19", {8'h0, h12, l12}, 16'h0019);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("carry_20", {8'h0, h12, l12}, 16'h0020);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("ena_off_hold", {8'h0, h12, l12}, 16'h0020);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      for (int j = 0; j < 3; j++) step(1'b1, 1'b1, 1'b1, 1'b0);
    end
    check("pulsed_23", {8'h0, h12, l12}, 16'h0023);

    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("load_98", {h98s, l98s, h98, l98}, 16'h9898);
    check("load_98_tc", {14'h0, tc98s, tc98}, 16'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("at_99", {h98s, l98s, h98, l98}, 16'h9999);
    check("at_99_tc", {14'h0, tc98s, tc98}, 16'h3);
    check("at_99_ov", {14'h0, ov98s, ov98}, 16'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("wrap_00", {8'h0, h98, l98}, 16'h0000);
    check("wrap_ov", {15'h0, ov98}, 16'h1);
    check("wrap_tc", {15'h0, tc98}, 16'h0);
    check("sat_99", {8'h0, h98s, l98s}, 16'h0099);
    check("sat_ov_tc", {14'h0, ov98s, tc98s}, 16'h1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("ov_one_cycle", {15'h0, ov98}, 16'h0);
    check("wrap_idle_00", {8'h0, h98, l98}, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("sat_hold", {7'h0, ov98s, h98s, l98s}, 16'h0099);

    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("load_07", {8'h0, h07, l07}, 16'h0007);
    for (int i = 0; i < 38; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    check("count_45", {8'h0, h07, l07}, 16'h0045);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("load_beats_tick", {8'h0, h07, l07}, 16'h0007);

    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    check("count_37", {8'h0, h12, l12}, 16'h0037);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("reset_mid", {8'h0, h12, l12}, 16'h0000);
    check("reset_mid_ov", {15'h0, ov12}, 16'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("resume_01", {8'h0, h12, l12}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
